// File: rtl/wb_pkg.sv
// ============================================================================
// Module  : wb_pkg
// Purpose : Shared types and codes for the write-back stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } wb_state_t;

  localparam logic [1:0] LS_WORD = 2'b00;
  localparam logic [1:0] LS_HALF = 2'b01;
  localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

`default_nettype wire

// File: rtl/wb_load_align.sv
// ============================================================================
// Module  : wb_load_align
// Purpose : Little-endian load-data alignment with sign/zero extension.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_byte_ext;
  logic        w_half_ext;

  always_comb begin
    w_byte     = rdata[{addr_lo, 3'b000} +: 8];
    w_half     = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    w_byte_ext = load_unsigned ? 1'b0 : w_byte[7];
    w_half_ext = load_unsigned ? 1'b0 : w_half[15];
    data       = rdata;
    // Reserved size code 2'b11 falls through to a full-word load.
    case (load_size)
      LS_HALF: data = {{(DATA_W-16){w_half_ext}}, w_half};
      LS_BYTE: data = {{(DATA_W-8){w_byte_ext}}, w_byte};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/wb_write_back.sv
// ============================================================================
// Module  : wb_write_back
// Purpose : Write-back stage: retires ALU results and loads into the regfile.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_back
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic [1:0]        in_addr_lo,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              RegWrite,
  output logic [REG_AW-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic [31:0]       retired_count
);

  wb_state_t         r_state;
  wb_state_t         w_state_next;
  logic              w_accept;
  logic              w_load_done;
  logic [DATA_W-1:0] w_aligned;

  logic              r_reg_write;
  logic [1:0]        r_load_size;
  logic              r_load_unsigned;
  logic [1:0]        r_addr_lo;
  logic              r_commit_we;
  logic [REG_AW-1:0] r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;
  logic [31:0]       r_count;

  assign in_ready    = (r_state == IDLE) || (r_state == COMMIT);
  assign w_accept    = in_valid && in_ready;
  assign w_load_done = (r_state == WAIT_MEM) && mem_rvalid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, COMMIT: begin
        if (w_accept) w_state_next = in_mem_to_reg ? WAIT_MEM : COMMIT;
        else          w_state_next = IDLE;
      end
      WAIT_MEM: if (mem_rvalid) w_state_next = COMMIT;
      default:  w_state_next = IDLE;
    endcase
  end

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata         (mem_rdata),
    .load_size     (r_load_size),
    .load_unsigned (r_load_unsigned),
    .addr_lo       (r_addr_lo),
    .data          (w_aligned)
  );

  // Commit outputs are loaded on the edge that enters COMMIT, so they are
  // registered and valid for exactly the COMMIT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_reg_write     <= 1'b0;
      r_load_size     <= LS_WORD;
      r_load_unsigned <= 1'b0;
      r_addr_lo       <= 2'b00;
      r_commit_we     <= 1'b0;
      r_wr_reg        <= '0;
      r_wr_data       <= '0;
      r_count         <= 32'd0;
    end else begin
      r_commit_we <= 1'b0;
      if (w_accept) begin
        r_reg_write     <= in_reg_write;
        r_load_size     <= in_load_size;
        r_load_unsigned <= in_load_unsigned;
        r_addr_lo       <= in_addr_lo;
        r_wr_reg        <= in_dest;
        r_wr_data       <= in_alu_result;
        if (!in_mem_to_reg) r_commit_we <= in_reg_write && (in_dest != '0);
      end else if (w_load_done) begin
        r_wr_data   <= w_aligned;
        r_commit_we <= r_reg_write && (r_wr_reg != '0);
      end
      if (w_state_next == COMMIT) r_count <= r_count + 32'd1;
    end
  end

  assign RegWrite       = r_commit_we;
  assign write_register = r_wr_reg;
  assign write_data     = r_wr_data;
  assign fwd_valid      = r_commit_we;
  assign fwd_reg        = r_wr_reg;
  assign fwd_data       = r_wr_data;
  assign retired_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_write_back.sv
// ============================================================================
// Module  : tb_wb_write_back
// Purpose : Self-checking bench for wb_write_back with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_write_back;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_reg_write, in_mem_to_reg;
  logic [1:0]  in_load_size, in_addr_lo;
  logic        in_load_unsigned;
  logic [31:0] in_alu_result;
  logic [4:0]  in_dest;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWrite, fwd_valid;
  logic [4:0]  write_register, fwd_reg;
  logic [31:0] write_data, fwd_data, retired_count;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_count = 32'd0;

  // Observations captured by the driver for the test tasks to compare.
  logic        obs_ready_at_accept, obs_wait_ok;
  logic        obs_we, obs_fv;
  logic [4:0]  obs_reg, obs_freg;
  logic [31:0] obs_data, obs_fdata, obs_count;

  always #5 clk = ~clk;

  wb_write_back #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .in_addr_lo(in_addr_lo), .in_alu_result(in_alu_result), .in_dest(in_dest),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retired_count(retired_count)
  );

  // Reference load result computed arithmetically from the byte-lane rules.
  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic uns, input logic [1:0] al);
    logic [31:0] v;
    if (sz == 2'b01) begin
      v = (word >> (16 * al[1])) % 32'd65536;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else if (sz == 2'b10) begin
      v = (word >> (8 * al)) % 32'd256;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic capture();
    obs_we = RegWrite;       obs_fv = fwd_valid;
    obs_reg = write_register; obs_freg = fwd_reg;
    obs_data = write_data;   obs_fdata = fwd_data;
    obs_count = retired_count;
  endtask

  // Presents one instruction, waits `lat` cycles in WAIT_MEM for loads,
  // returns with the DUT in its commit cycle and the outputs captured.
  task automatic issue(input logic rw, input logic m2r, input logic [1:0] sz, input logic uns,
                       input logic [1:0] al, input logic [31:0] alu, input logic [4:0] dst,
                       input logic [31:0] rdata, input int lat);
    obs_ready_at_accept = in_ready;
    in_valid = 1'b1; in_reg_write = rw; in_mem_to_reg = m2r; in_load_size = sz;
    in_load_unsigned = uns; in_addr_lo = al; in_alu_result = alu; in_dest = dst;
    step();
    in_valid = 1'b0; in_alu_result = $urandom; in_dest = 5'($urandom);
    obs_wait_ok = 1'b1;
    if (m2r) begin
      for (int i = 0; i < lat; i++) begin
        if (in_ready !== 1'b0 || RegWrite !== 1'b0) obs_wait_ok = 1'b0;
        step();
      end
      if (in_ready !== 1'b0) obs_wait_ok = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
    exp_count = exp_count + 32'd1;
    capture();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 1'b0; in_reg_write = 1'b0; in_mem_to_reg = 1'b0; in_load_size = 2'b00;
    in_load_unsigned = 1'b0; in_addr_lo = 2'b00; in_alu_result = '0; in_dest = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    n_cmp++;
    if ({RegWrite, fwd_valid, write_register, write_data, retired_count, in_ready} !==
        {1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got we=%b fv=%b reg=%0d data=%h cnt=%0d rdy=%b, want 0 0 0 0 0 1",
               RegWrite, fwd_valid, write_register, write_data, retired_count, in_ready);
    end
    reset_n = 1'b1;
    step();
    exp_count = 32'd0;
  endtask

  task automatic test_alu();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h1234, 5'd8, 32'd0, 0);
    n_cmp++;
    if ({obs_we, obs_reg, obs_data, obs_count} !== {1'b1, 5'd8, 32'h1234, 32'd1}) begin
      n_err++;
      $display("FAIL alu_commit: got we=%b reg=%0d data=%h cnt=%0d, want 1 8 00001234 1",
               obs_we, obs_reg, obs_data, obs_count);
    end
    n_cmp++;
    if ({obs_fv, obs_freg, obs_fdata} !== {obs_we, obs_reg, obs_data} || obs_fv !== 1'b1) begin
      n_err++;
      $display("FAIL alu_fwd: got fv=%b reg=%0d data=%h, want 1 8 00001234", obs_fv, obs_freg, obs_fdata);
    end
    step();
    n_cmp++;
    if (RegWrite !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL alu_to_idle: got we=%b rdy=%b, want 0 1", RegWrite, in_ready);
    end
  endtask

  task automatic test_signed_byte();
    issue(1'b1, 1'b1, 2'b10, 1'b0, 2'b01, 32'hDEAD_0000, 5'd3, 32'h0000_8000, 2);
    n_cmp++;
    if (obs_wait_ok !== 1'b1) begin
      n_err++;
      $display("FAIL sbyte_wait: in_ready/RegWrite not low while waiting, got ok=%b want 1", obs_wait_ok);
    end
    n_cmp++;
    if ({obs_we, obs_reg, obs_data, obs_count} !== {1'b1, 5'd3, 32'hFFFF_FF80, exp_count}) begin
      n_err++;
      $display("FAIL sbyte_data: got we=%b reg=%0d data=%h cnt=%0d, want 1 3 ffffff80 %0d",
               obs_we, obs_reg, obs_data, obs_count, exp_count);
    end
    step();
  endtask

  task automatic test_unsigned_half();
    issue(1'b1, 1'b1, 2'b01, 1'b1, 2'b10, 32'h0, 5'd17, 32'hBEEF_0000, 1);
    n_cmp++;
    if ({obs_we, obs_reg, obs_data} !== {1'b1, 5'd17, 32'h0000_BEEF}) begin
      n_err++;
      $display("FAIL uhalf_data: got we=%b reg=%0d data=%h, want 1 17 0000beef", obs_we, obs_reg, obs_data);
    end
    step();
  endtask

  task automatic test_dest_zero();
    issue(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'hCAFE_F00D, 5'd0, 32'd0, 0);
    n_cmp++;
    if ({obs_we, obs_fv, obs_count} !== {1'b0, 1'b0, exp_count}) begin
      n_err++;
      $display("FAIL dest_zero: got we=%b fv=%b cnt=%0d, want 0 0 %0d", obs_we, obs_fv, obs_count, exp_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic        ok;
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    ok = 1'b1;
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_alu_result = vals[i]; in_dest = 5'(i + 10);
      if (in_ready !== 1'b1) ok = 1'b0;
      step();
      exp_count = exp_count + 32'd1;
      if (RegWrite !== 1'b1 || write_register !== 5'(i + 10) || write_data !== vals[i] ||
          retired_count !== exp_count) ok = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_stream: got ok=%b, want 1 (four consecutive in-order commits)", ok);
    end
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_rvalid = 1'b0;
    n_cmp++;
    if ({RegWrite, in_ready, retired_count} !== {1'b0, 1'b1, exp_count}) begin
      n_err++;
      $display("FAIL stray_rvalid: got we=%b rdy=%b cnt=%0d, want 0 1 %0d",
               RegWrite, in_ready, retired_count, exp_count);
    end
  endtask

  task automatic test_reset_in_wait();
    logic saw_we;
    in_valid = 1'b1; in_reg_write = 1'b1; in_mem_to_reg = 1'b1; in_load_size = 2'b00;
    in_dest = 5'd9;
    step();
    in_valid = 1'b0;
    step();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({RegWrite, in_ready, retired_count} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL rst_wait_async: got we=%b rdy=%b cnt=%0d, want 0 1 0", RegWrite, in_ready, retired_count);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    step();
    reset_n = 1'b1;
    saw_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (RegWrite !== 1'b0) saw_we = 1'b1;
    end
    mem_rvalid = 1'b0;
    exp_count = 32'd0;
    n_cmp++;
    if ({saw_we, in_ready, retired_count} !== {1'b0, 1'b1, 32'd0}) begin
      n_err++;
      $display("FAIL rst_wait_after: got we_seen=%b rdy=%b cnt=%0d, want 0 1 0", saw_we, in_ready, retired_count);
    end
  endtask

  task automatic test_random();
    logic        rw, m2r, uns;
    logic [1:0]  sz, al;
    logic [31:0] alu, rdata, exp_data;
    logic [4:0]  dst;
    logic        exp_we;
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom); m2r = 1'($urandom); uns = 1'($urandom);
      sz = 2'($urandom); al = 2'($urandom); alu = $urandom; rdata = $urandom;
      dst = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      exp_we   = rw && (dst != 5'd0);
      exp_data = m2r ? model_load(rdata, sz, uns, al) : alu;
      issue(rw, m2r, sz, uns, al, alu, dst, rdata, $urandom_range(0, 3));
      n_cmp++;
      if (obs_ready_at_accept !== 1'b1 || obs_wait_ok !== 1'b1) begin
        n_err++;
        $display("FAIL rand_ready[%0d]: got rdy=%b wait_ok=%b, want 1 1", n, obs_ready_at_accept, obs_wait_ok);
      end
      n_cmp++;
      if (obs_we !== exp_we || obs_data !== exp_data || obs_count !== exp_count ||
          (exp_we && obs_reg !== dst) || {obs_fv, obs_freg, obs_fdata} !== {obs_we, obs_reg, obs_data}) begin
        n_err++;
        $display("FAIL rand_commit[%0d]: got we=%b reg=%0d data=%h cnt=%0d, want we=%b reg=%0d data=%h cnt=%0d",
                 n, obs_we, obs_reg, obs_data, obs_count, exp_we, dst, exp_data, exp_count);
      end
      if ($urandom_range(0, 1) == 0) step();
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_signed_byte();
    test_unsigned_half();
    test_dest_zero();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_write_back.md
WB_WRITE_BACK -- requirements
Module: wb_write_back

Interface
REQ-001 SHALL have parameter DATA_W, 32, datapath and register width.
REQ-002 SHALL have parameter REG_AW, 5, register-index width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  in  1  MEM stage presents a retiring instruction.
REQ-006 SHALL have port in_ready  out  1  block accepts the presented instruction this cycle.
REQ-007 SHALL have ports in_reg_write (in, 1, instruction writes a register) and in_mem_to_reg (in, 1, result comes from a memory load).
REQ-008 SHALL have ports in_load_size (in, 2, 00 word, 01 half, 10 byte, 11 reserved=word), in_load_unsigned (in, 1, zero-extend) and in_addr_lo (in, 2, load byte offset).
REQ-009 SHALL have ports in_alu_result (in, DATA_W) and in_dest (in, REG_AW, destination register).
REQ-010 SHALL have ports mem_rvalid (in, 1, load data returned) and mem_rdata (in, DATA_W, load word).
REQ-011 SHALL have ports RegWrite (out, 1), write_register (out, REG_AW) and write_data (out, DATA_W), which drive the register-file write port.
REQ-012 SHALL have ports fwd_valid (out, 1), fwd_reg (out, REG_AW) and fwd_data (out, DATA_W), the forwarding copy of the commit.
REQ-013 SHALL have port retired_count  out  32  count of committed instructions.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT_MEM and COMMIT.
REQ-015 SHALL accept an instruction when in_valid && in_ready, latching all in_* fields; in_ready = (state==IDLE || state==COMMIT).
REQ-016 On accept with in_mem_to_reg=0, SHALL go to COMMIT next cycle with write_data = latched alu_result.
REQ-017 On accept with in_mem_to_reg=1, SHALL go to WAIT_MEM and stay there until mem_rvalid=1, then capture the aligned data and go to COMMIT.
REQ-018 SHALL ignore mem_rvalid in IDLE and COMMIT; no state or data change.
REQ-019 Alignment is little-endian: byte = mem_rdata[8*addr_lo+7 : 8*addr_lo]; half = addr_lo[1] ? [31:16] : [15:0], with addr_lo[0] ignored; word ignores addr_lo.
REQ-020 Byte and half loads SHALL zero-extend when in_load_unsigned=1, otherwise sign-extend from the top bit of the field.
REQ-021 In COMMIT, RegWrite SHALL be 1 for exactly that cycle iff latched reg_write=1 and dest!=0; write_register and write_data SHALL be valid in that cycle.
REQ-022 fwd_valid, fwd_reg and fwd_data SHALL equal RegWrite, write_register and write_data in every cycle.
REQ-023 Leaving COMMIT: SHALL go to IDLE if no accept occurs that cycle; otherwise it is a back-to-back accept handled per REQ-016/017.
REQ-024 Latency: an ALU op accepted in cycle N commits in N+1. A load commits one cycle after the cycle in which mem_rvalid is sampled in WAIT_MEM.
REQ-025 Throughput: one ALU op per cycle with in_valid held high.
REQ-026 retired_count SHALL increment by 1 on every COMMIT cycle, including dest=0 and reg_write=0 commits; it wraps from 0xFFFFFFFF to 0.
REQ-027 Outputs RegWrite, write_register, write_data and fwd_* SHALL come from registers, with no combinational path from in_*.

Reset
REQ-028 While reset_n=0: state=IDLE; RegWrite=0, fwd_valid=0, write_register=0, write_data=0, retired_count=0; in_ready=1.
REQ-029 Reset asserted in WAIT_MEM or COMMIT SHALL discard the instruction: no write, no count.

Structure
REQ-030 Package wb_pkg SHALL hold the state enum and the load-size codes (LS_WORD, LS_HALF, LS_BYTE).
REQ-031 Sub-module wb_load_align SHALL implement REQ-019/020 combinationally.

Verification
REQ-032 ALU op: alu_result=0x1234, dest=8 accepted in cycle 5 -> cycle 6 RegWrite=1, write_register=8, write_data=0x1234, retired_count=1.
REQ-033 Signed byte load: mem_rdata=0x0000_8000, addr_lo=01, mem_rvalid 3 cycles after accept -> write_data=0xFFFFFF80 one cycle after mem_rvalid; in_ready=0 while waiting.
REQ-034 Unsigned half load: mem_rdata=0xBEEF_0000, addr_lo=10 -> write_data=0x0000BEEF.
REQ-035 dest=0 with reg_write=1 -> RegWrite=0, fwd_valid=0, retired_count still increments.
REQ-036 Four back-to-back ALU ops -> RegWrite high for four consecutive cycles in order; a stray mem_rvalid pulse in IDLE has no effect.
REQ-037 reset_n low during WAIT_MEM -> no commit; after release, state=IDLE, retired_count=0.
